// File: rtl/sample_capture.sv
// Triggered sample recorder: arms on request, starts storing on a rising crossing of
// trig_level, and fills a DEPTH-word buffer. Define SAMPLE_CAPTURE_LOOP_EN for ring recording.
module sample_capture #(
    parameter int DEPTH = 50,
    parameter int AW    = 6
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          arm,
    input  logic          stop,
    input  logic [7:0]    trig_level,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] wr_count
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] ptr, ptr_nxt, cnt_nxt, waddr;
    logic [7:0]    prev, prev_nxt;
    logic          we, accept, trig;
    logic [7:0]    mem [DEPTH];

    assign accept = in_valid & in_ready;
    // Rising crossing: previous sample below the level, current at or above it.
    assign trig   = (prev < trig_level) && (in_data >= trig_level);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = wr_count;
        prev_nxt  = prev;
        we        = 1'b0;
        waddr     = ptr;
        case (state)
            IDLE, DONE: begin
                if (arm && !stop) begin
                    state_nxt = ARMED;
                    ptr_nxt   = '0;
                    cnt_nxt   = '0;
                    prev_nxt  = 8'hFF;
                end
            end
            ARMED: begin
                if (accept) begin
                    prev_nxt = in_data;
                    if (trig) begin
                        we        = 1'b1;
                        waddr     = '0;
                        ptr_nxt   = AW'(1);
                        cnt_nxt   = AW'(1);
                        state_nxt = CAPTURE;
                    end
                end
                if (stop) state_nxt = DONE;
            end
            CAPTURE: begin
                if (accept) begin
                    we = 1'b1;
`ifdef SAMPLE_CAPTURE_LOOP_EN
                    ptr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;
                    cnt_nxt = (wr_count == DEPTH_A) ? wr_count : wr_count + 1'b1;
`else
                    ptr_nxt = ptr + 1'b1;
                    cnt_nxt = wr_count + 1'b1;
                    if (wr_count == LAST) state_nxt = DONE;
`endif
                end
                // stop wins, but the sample accepted alongside it is still kept
                if (stop) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            wr_count <= '0;
            prev     <= 8'hFF;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            wr_count <= cnt_nxt;
            prev     <= prev_nxt;
            in_ready <= (state_nxt == ARMED) || (state_nxt == CAPTURE);
            busy     <= (state_nxt == ARMED) || (state_nxt == CAPTURE);
            done     <= (state_nxt == DONE);
        end
    end

    // Storage is never cleared; a reset only blocks the write in that cycle.
    always_ff @(posedge Clk) begin
        if (we && Reset_n) mem[waddr] <= in_data;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n)               rd_data <= 8'h00;
        else if (rd_addr < DEPTH_A) rd_data <= mem[rd_addr];
        else                        rd_data <= 8'h00;
    end

endmodule
